// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a C/S/Z/P flag register and valid/ready issue.
// Single-cycle ops write out/flags on the accept edge; out_valid pulses the
// following cycle. Build option ALU_MUL_EN turns op E into a WIDTH-cycle
// unsigned shift-add multiplier. Without it, op E passes a through and leaves
// the flags alone.
//
// state       | meaning
// ST_IDLE     | accepting; single-cycle ops complete on the accept edge
// ST_MUL_BUSY | shift-add multiply in progress, in_valid ignored
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             use_ext_c,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_valid,
  output logic             C,
  output logic             S,
  output logic             Z,
  output logic             P
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_DEC  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_PASS = 4'hF;

  logic             carry_src;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c_res;
  logic             flags_wr;
  logic             single_wr;

  // Single-cycle result and carry; borrow falls out as the top bit of the
  // WIDTH+1-bit difference.
  always_comb begin
    carry_src = use_ext_c ? cin : C;
    sum       = '0;
    res       = '0;
    c_res     = 1'b0;
    flags_wr  = 1'b1;
    case (op)
      OP_ADD:  begin sum = {1'b0, a} + {1'b0, b}; res = sum[WIDTH-1:0]; c_res = sum[WIDTH]; end
      OP_ADC:  begin sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_src};
                     res = sum[WIDTH-1:0]; c_res = sum[WIDTH]; end
      OP_SUB:  begin sum = {1'b0, a} - {1'b0, b}; res = sum[WIDTH-1:0]; c_res = sum[WIDTH]; end
      OP_SBB:  begin sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_src};
                     res = sum[WIDTH-1:0]; c_res = sum[WIDTH]; end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL:  begin res = {a[WIDTH-2:0], 1'b0}; c_res = a[WIDTH-1]; end
      OP_SHR:  begin res = {1'b0, a[WIDTH-1:1]}; c_res = a[0]; end
      OP_ROL:  begin res = {a[WIDTH-2:0], carry_src}; c_res = a[WIDTH-1]; end
      OP_ROR:  begin res = {carry_src, a[WIDTH-1:1]}; c_res = a[0]; end
      OP_INC:  begin sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1}; res = sum[WIDTH-1:0]; c_res = sum[WIDTH]; end
      OP_DEC:  begin sum = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1}; res = sum[WIDTH-1:0]; c_res = sum[WIDTH]; end
      // Single-cycle op E (multiplier absent): pass a, flags untouched.
      OP_MUL:  begin res = a; flags_wr = 1'b0; end
      OP_PASS: res = b;
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     mul_sum;

  // One shift-add step: add multiplicand into the high half when the current
  // multiplier LSB (prod[0]) is set, then shift the whole product right.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod_next = {mul_sum, prod[WIDTH-1:1]};
  end

  assign in_ready  = (state == ST_IDLE);
  assign single_wr = in_valid && in_ready && (op != OP_MUL);
`else
  assign in_ready  = 1'b1;
  assign single_wr = in_valid;
`endif

  // Result/flag registers, output strobe and multiplier sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_hi    <= '0;
      out_valid <= 1'b0;
      C         <= 1'b0;
      S         <= 1'b0;
      Z         <= 1'b0;
      P         <= 1'b0;
`ifdef ALU_MUL_EN
      state     <= ST_IDLE;
      cnt       <= '0;
      mcand     <= '0;
      prod      <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (single_wr) begin
        out       <= res;
        out_hi    <= '0;
        out_valid <= 1'b1;
        if (flags_wr) begin
          C <= c_res;
          S <= res[WIDTH-1];
          Z <= (res == '0);
          P <= ~^res;
        end
      end
`ifdef ALU_MUL_EN
      if (state == ST_IDLE) begin
        if (in_valid && op == OP_MUL) begin
          state <= ST_MUL_BUSY;
          cnt   <= '0;
          mcand <= a;
          prod  <= {{WIDTH{1'b0}}, b};
        end
      end else begin
        prod <= prod_next;
        cnt  <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH-1)) begin
          out       <= prod_next[WIDTH-1:0];
          out_hi    <= prod_next[2*WIDTH-1:WIDTH];
          out_valid <= 1'b1;
          C         <= |prod_next[2*WIDTH-1:WIDTH];
          S         <= prod_next[WIDTH-1];
          Z         <= (prod_next == '0);
          P         <= ~^prod_next[WIDTH-1:0];
          state     <= ST_IDLE;
        end
      end
`endif
    end
  end

endmodule
